// File: rtl/strobed_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : strobed_decoder_pkg
// Purpose : Shared types and constants for the strobed decoder.
//           - state_e   : pulse FSM states (IDLE, ACTIVE)
//           - cnt_width : maps PULSE_LEN to the width of the pulse counter
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package strobed_decoder_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // The counter only has to hold PULSE_LEN-1, so $clog2(PULSE_LEN) bits
    // suffice; PULSE_LEN=1 would give zero bits, so keep at least one.
    function automatic int cnt_width(input int pulse_len);
        return (pulse_len > 1) ? $clog2(pulse_len) : 1;
    endfunction

endpackage : strobed_decoder_pkg
`default_nettype wire

// File: rtl/strobed_decoder_onehot_low_dec.sv
`default_nettype none
// ============================================================================
// Module  : onehot_low_dec
// Purpose : Combinational SEL_W-to-2**SEL_W active-low decoder with a single
//           enable. When enabled exactly one output is low, otherwise all
//           outputs are high.
// Ports   : sel_i    [SEL_W-1:0]   select
//           en_i                   enable (active high)
//           out_b_o  [OUT_N-1:0]   active-low one-hot-low outputs
// Rev     : 1.0  initial release
// ============================================================================
module onehot_low_dec #(
    parameter  int SEL_W = 3,
    localparam int OUT_N = 2**SEL_W
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [OUT_N-1:0] out_b_o
);

    always_comb begin
        out_b_o = '1;
        if (en_i) begin
            out_b_o[sel_i] = 1'b0;
        end
    end

endmodule : onehot_low_dec
`default_nettype wire

// File: rtl/strobed_decoder.sv
`default_nettype none
// ============================================================================
// Module  : strobed_decoder
// Purpose : Strobed SEL_W-to-2**SEL_W active-low decoder. A qualified strobe
//           (en_g1 & ~en_g2a_b & ~en_g2b_b & ~abort) latches sel and drives
//           exactly one q_b bit low for PULSE_LEN cycles, then releases it
//           and flags done for one cycle. abort cancels an active pulse
//           without done. All outputs come straight from flops.
// Config  : `define STROBED_DECODER_BACK_TO_BACK_EN lets a qualified strobe
//           in the final active cycle start the next pulse with no gap.
// Ports   : clk                    rising-edge clock
//           rst_n                  asynchronous active-low reset
//           sel      [SEL_W-1:0]   select, sampled on accepted strobe
//           en_g1                  active-high enable
//           en_g2a_b, en_g2b_b     active-low enables
//           strobe                 pulse request
//           abort                  synchronous cancel
//           q_b      [OUT_N-1:0]   registered active-low outputs
//           busy                   high while a pulse is active
//           done                   one-cycle completion flag
// Rev     : 1.0  initial release
// ============================================================================
module strobed_decoder #(
    parameter  int SEL_W     = 3,
    parameter  int PULSE_LEN = 1,
    localparam int OUT_N     = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic             en_g1,
    input  logic             en_g2a_b,
    input  logic             en_g2b_b,
    input  logic             strobe,
    input  logic             abort,
    output logic [OUT_N-1:0] q_b,
    output logic             busy,
    output logic             done
);

    import strobed_decoder_pkg::*;

    localparam int               CNT_W    = cnt_width(PULSE_LEN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               done_d;
    logic               busy_d;
    logic [OUT_N-1:0]   q_b_d;
    logic               accept;

    // Enables are only looked at here, so changes during a pulse are inert.
    assign accept = strobe & en_g1 & ~en_g2a_b & ~en_g2b_b & ~abort;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACTIVE;
                    sel_d   = sel;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef STROBED_DECODER_BACK_TO_BACK_EN
                    // Relatch in the last active cycle: the next pulse
                    // starts on the very next cycle while done still fires.
                    if (accept) begin
                        state_d = ACTIVE;
                        sel_d   = sel;
                        cnt_d   = CNT_LOAD;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode the next-state select so q_b is registered in the same edge
    // that enters/leaves ACTIVE, keeping it aligned with busy.
    assign busy_d = (state_d == ACTIVE);

    onehot_low_dec #(
        .SEL_W   (SEL_W)
    ) u_dec (
        .sel_i   (sel_d),
        .en_i    (busy_d),
        .out_b_o (q_b_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            q_b     <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            q_b     <= q_b_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule : strobed_decoder
`default_nettype wire

// File: tb/tb_strobed_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_strobed_decoder
// Purpose : Self-checking bench for strobed_decoder. Three instances share
//           one stimulus stream: (SEL_W=3,PULSE_LEN=4), (3,2) and (6,255).
//           A per-instance model tracks remaining low cycles of the pulse.
// Rev     : 1.0  initial release
// ============================================================================
module tb_strobed_decoder;

    localparam int NI = 3;
`ifdef STROBED_DECODER_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  sel;
    logic        en_g1, en_g2a_b, en_g2b_b, strobe, abort;
    logic [7:0]  q_b0, q_b1;
    logic [63:0] q_b2;
    logic        busy0, busy1, busy2, done0, done1, done2;

    always #5 clk = ~clk;

    strobed_decoder #(.SEL_W(3), .PULSE_LEN(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel[2:0]), .en_g1(en_g1),
        .en_g2a_b(en_g2a_b), .en_g2b_b(en_g2b_b), .strobe(strobe),
        .abort(abort), .q_b(q_b0), .busy(busy0), .done(done0));

    strobed_decoder #(.SEL_W(3), .PULSE_LEN(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel[2:0]), .en_g1(en_g1),
        .en_g2a_b(en_g2a_b), .en_g2b_b(en_g2b_b), .strobe(strobe),
        .abort(abort), .q_b(q_b1), .busy(busy1), .done(done1));

    strobed_decoder #(.SEL_W(6), .PULSE_LEN(255)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .en_g1(en_g1),
        .en_g2a_b(en_g2a_b), .en_g2b_b(en_g2b_b), .strobe(strobe),
        .abort(abort), .q_b(q_b2), .busy(busy2), .done(done2));

    // ---------------- reference model ----------------
    int sw [NI] = '{3, 3, 6};
    int pl [NI] = '{4, 2, 255};
    int rem   [NI];   // remaining cycles the selected output stays low
    int msel  [NI];
    bit mdone [NI];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            rem[i]   = 0;
            msel[i]  = 0;
            mdone[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit qual;
        int s;
        qual = en_g1 && !en_g2a_b && !en_g2b_b;
        for (int i = 0; i < NI; i++) begin
            s = int'(sel) % (1 << sw[i]);
            mdone[i] = 1'b0;
            if (rem[i] > 0) begin
                if (abort) begin
                    rem[i] = 0;
                end else if (rem[i] == 1) begin
                    mdone[i] = 1'b1;
                    rem[i]   = 0;
                    if (B2B && strobe && qual) begin
                        rem[i]  = pl[i];
                        msel[i] = s;
                    end
                end else begin
                    rem[i] = rem[i] - 1;
                end
            end else if (strobe && qual && !abort) begin
                rem[i]  = pl[i];
                msel[i] = s;
            end
        end
    endtask

    function automatic logic [63:0] exp_q(input int i);
        logic [63:0] mask;
        mask = (sw[i] >= 6) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (1 << sw[i])) - 64'h1);
        return (rem[i] > 0) ? (~(64'h1 << msel[i]) & mask) : mask;
    endfunction

    logic [63:0] gq [NI];
    logic        gb [NI];
    logic        gd [NI];
    always_comb begin
        gq[0] = 64'(q_b0); gq[1] = 64'(q_b1); gq[2] = q_b2;
        gb[0] = busy0;     gb[1] = busy1;     gb[2] = busy2;
        gd[0] = done0;     gd[1] = done1;     gd[2] = done2;
    end

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("q_b[%0d]", i),  gq[i],        exp_q(i));
            chk($sformatf("busy[%0d]", i), 64'(gb[i]),   64'(rem[i] > 0));
            chk($sformatf("done[%0d]", i), 64'(gd[i]),   64'(mdone[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lows;
        int dones;
        rst_n = 1'b0; sel = '0; en_g1 = 1'b1; en_g2a_b = 1'b0; en_g2b_b = 1'b0;
        strobe = 1'b0; abort = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        chk("rst_q_b0", 64'(q_b0), 64'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic pulse, sel=5; sel wiggles during the pulse.
        sel = 6'd5; strobe = 1'b1;
        step();
        strobe = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("pulse_q_b0", 64'(q_b0), 64'hDF);
            chk("pulse_busy0", 64'(busy0), 64'h1);
            sel = 6'($urandom);
            step();
        end
        chk("end_q_b0", 64'(q_b0), 64'hFF);
        chk("end_done0", 64'(done0), 64'h1);
        step();

        // Unqualified enables: no pulse.
        en_g2a_b = 1'b1; strobe = 1'b1; sel = 6'd3;
        step();
        chk("g2a_busy0", 64'(busy0), 64'h0);
        en_g2a_b = 1'b0; en_g1 = 1'b0;
        step();
        chk("g1_q_b0", 64'(q_b0), 64'hFF);
        strobe = 1'b0; en_g1 = 1'b1;
        step(); step();

        // Continuous strobe on the PULSE_LEN=2 instance.
        sel = 6'd2; strobe = 1'b1;
        step();
        lows = 0; dones = 0;
        for (int j = 0; j < 9; j++) begin
            if (q_b1 == 8'hFB) lows++;
            if (done1) dones++;
            if (j < 8) step();
        end
        chk("cont_lows", 64'(lows), B2B ? 64'd9 : 64'd6);
        chk("cont_dones", 64'(dones), B2B ? 64'd4 : 64'd3);
        strobe = 1'b0;
        for (int n = 0; n < 12 && busy0; n++) step();
        chk("idle0_a", 64'(busy0), 64'h0);
        step();

        // Abort in the 2nd active cycle.
        sel = 6'd1; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_q_b0", 64'(q_b0), 64'hFF);
        chk("abort_busy0", 64'(busy0), 64'h0);
        for (int j = 0; j < 3; j++) begin
            chk("abort_nodone0", 64'(done0), 64'h0);
            step();
        end

        // Abort together with strobe in IDLE.
        abort = 1'b1; strobe = 1'b1;
        step();
        chk("abort_idle_busy0", 64'(busy0), 64'h0);
        abort = 1'b0; strobe = 1'b0;
        step();

        // Long pulse on SEL_W=6, PULSE_LEN=255, sel=63.
        for (int n = 0; n < 300 && busy2; n++) step();
        chk("idle2", 64'(busy2), 64'h0);
        sel = 6'd63; strobe = 1'b1;
        step();
        strobe = 1'b0;
        lows = 0;
        for (int j = 0; j < 260; j++) begin
            if (q_b2 == 64'h7FFF_FFFF_FFFF_FFFF) lows++;
            step();
        end
        chk("long_lows", 64'(lows), 64'd255);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            sel      = 6'($urandom);
            en_g1    = ($urandom % 8) != 0;
            en_g2a_b = ($urandom % 8) == 0;
            en_g2b_b = ($urandom % 8) == 0;
            strobe   = ($urandom % 4) == 0;
            abort    = ($urandom % 16) == 0;
            step();
        end

        // Asynchronous reset in the middle of a pulse.
        en_g1 = 1'b1; en_g2a_b = 1'b0; en_g2b_b = 1'b0; strobe = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0; sel = 6'd6; strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        chk("pre_rst_busy0", 64'(busy0), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q_b0", 64'(q_b0), 64'hFF);
        chk("arst_busy0", 64'(busy0), 64'h0);
        chk("arst_done0", 64'(done0), 64'h0);
        chk("arst_q_b2", q_b2, 64'hFFFF_FFFF_FFFF_FFFF);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule : tb_strobed_decoder
`default_nettype wire
